// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Handshake and result bundle between the control unit and the
//   multiply/divide sequencer.
//
//   master (control unit): drives start_mult, start_div, a, b;
//                          observes busy, done, div_zero, hi, lo.
//   slave  (sequencer):    the reverse.
//
//   Parameter WIDTH: operand width; hi and lo are each WIDTH bits.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_div, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative signed multiplier (radix-2 Booth) and restoring divider
//   driving the HI/LO register pair. One step per clock.
//
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-high reset
//     bus    - muldiv_sequencer_if.slave: start_mult/start_div/a/b in,
//              busy/done/div_zero/hi/lo out
//
//   Optional feature macro: MULDIV_DIVZERO_EXC_EN
//     defined   - a divide with b == 0 skips straight to FIN, leaves HI/LO
//                 untouched and pulses div_zero together with done.
//     undefined - div_zero stays 0 and b == 0 runs the full divide.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, DFIX, FIN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic             last_step;
  logic             busy, done;
  logic [WIDTH-1:0] hi_r, lo_r;

  // Booth registers; acc carries one guard bit so that subtracting the most
  // negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc, mcand;
  logic [WIDTH-1:0] q;
  logic             q_1;

  // Divider registers, working on magnitudes.
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             sign_a, sign_b;
  logic             dz_flag;

  logic             div_by_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

`ifdef MULDIV_DIVZERO_EXC_EN
  assign div_by_zero = (bus.b == '0);
`else
  assign div_by_zero = 1'b0;
`endif

  assign abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign last_step = (count == CW'(WIDTH - 1));

  // One Booth step: add/subtract by the {q0, q-1} pair, then arithmetic
  // shift of the whole {acc, q, q-1} register.
  logic [WIDTH:0]   booth_sum, acc_next;
  logic [WIDTH-1:0] q_next;
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_next   = {booth_sum[0], q[WIDTH-1:1]};
  end

  // One restoring-division step, plus the sign fix-up applied in DFIX.
  // The remainder never reaches WIDTH bits after subtraction, so the
  // difference can be taken modulo 2^WIDTH.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff, rem_next, quo_next, rem_fixed, quo_fixed;
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, dvsr});
    div_diff  = div_shift[WIDTH-1:0] - dvsr;
    rem_next  = div_fits ? div_diff : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_fits};
    quo_fixed = (sign_a ^ sign_b) ? -quo : quo;
    rem_fixed = sign_a ? -rem : rem;
  end

  // Next-state and status outputs. Starts are looked at only in IDLE;
  // multiply wins when both starts arrive together.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_mult)     state_next = MUL;
        else if (bus.start_div) state_next = div_by_zero ? FIN : DIV;
      end
      MUL: begin
        busy = 1'b1;
        if (last_step) state_next = FIN;
      end
      DIV: begin
        busy = 1'b1;
        if (last_step) state_next = DFIX;
      end
      DFIX: begin
        busy       = 1'b1;
        state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath. HI/LO are written only on the edge that
  // enters FIN, so MFHI/MFLO during an operation see the previous result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      dz_flag <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          count   <= '0;
          dz_flag <= 1'b0;
          if (bus.start_mult) begin
            acc   <= '0;
            mcand <= {bus.a[WIDTH-1], bus.a};
            q     <= bus.b;
            q_1   <= 1'b0;
          end else if (bus.start_div) begin
            rem     <= '0;
            quo     <= abs_a;
            dvsr    <= abs_b;
            sign_a  <= bus.a[WIDTH-1];
            sign_b  <= bus.b[WIDTH-1];
            dz_flag <= div_by_zero;
          end
        end
        MUL: begin
          acc   <= acc_next;
          q     <= q_next;
          q_1   <= q[0];
          count <= count + 1'b1;
          if (last_step) begin
            hi_r <= acc_next[WIDTH-1:0];
            lo_r <= q_next;
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
        end
        DFIX: begin
          hi_r <= rem_fixed;
          lo_r <= quo_fixed;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = done & dz_flag;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed self-checking bench for muldiv_sequencer. Inputs change and
//   outputs are sampled on the falling clock edge. Expected results under
//   both settings of MULDIV_DIVZERO_EXC_EN are hand-computed constants.
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start request on the next falling edge; the following rising
  // edge is the accepting edge k.
  task automatic applyStimulus(input logic sm, input logic sd,
                               input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.a          = av;
    bus.b          = bv;
  endtask

  // Start one operation and watch it for a bounded number of cycles.
  // Cycle n is the n-th cycle after the accepting edge. Returns the done
  // cycle (-1 if never seen), busy cycle count, div_zero/busy in the done
  // cycle, and how many pre-done cycles had HI/LO differ from hold values.
  task automatic run_op(input logic sm, input logic sd,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                        output int done_cyc, output int busy_cnt,
                        output logic dz, output logic busy_at_done,
                        output int hold_viol);
    applyStimulus(sm, sd, av, bv);
    done_cyc     = -1;
    busy_cnt     = 0;
    dz           = 1'b0;
    busy_at_done = 1'b0;
    hold_viol    = 0;
    for (int n = 1; n <= 60 && done_cyc < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cyc     = n;
        dz           = bus.div_zero;
        busy_at_done = bus.busy;
      end else if (bus.hi !== hold_hi || bus.lo !== hold_lo) begin
        hold_viol++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("[TB] FAIL reset_div_zero: got %b expected 0", bus.div_zero); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    int dc, bc, hv; logic dz, bd;
    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, dc, bc, dz, bd, hv);
    total++; if (dc !== 33) $display("[TB] FAIL mult_done_cycle: got %0d expected 33", dc); else passed++;
    total++; if (bc !== 32) $display("[TB] FAIL mult_busy_cycles: got %0d expected 32", bc); else passed++;
    total++; if (bd !== 1'b0) $display("[TB] FAIL mult_busy_at_done: got %b expected 0", bd); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_hi: got %h expected ffffffff", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFEB) $display("[TB] FAIL mult_lo: got %h expected ffffffeb", bus.lo); else passed++;
    total++; if (hv !== 0) $display("[TB] FAIL mult_hilo_hold: got %0d changes expected 0", hv); else passed++;
  endtask

  task automatic test_div_signed();
    int dc, bc, hv; logic dz, bd;
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, dc, bc, dz, bd, hv);
    total++; if (dc !== 34) $display("[TB] FAIL div_done_cycle: got %0d expected 34", dc); else passed++;
    total++; if (bc !== 33) $display("[TB] FAIL div_busy_cycles: got %0d expected 33", bc); else passed++;
    total++; if (dz !== 1'b0) $display("[TB] FAIL div_dz: got %b expected 0", dz); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFFD) $display("[TB] FAIL div_lo: got %h expected fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFF) $display("[TB] FAIL div_hi: got %h expected ffffffff", bus.hi); else passed++;
    total++; if (hv !== 0) $display("[TB] FAIL div_hilo_hold: got %0d changes expected 0", hv); else passed++;
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, dc, bc, dz, bd, hv);
    total++; if (dc !== 34) $display("[TB] FAIL divovf_done_cycle: got %0d expected 34", dc); else passed++;
    total++; if (bus.lo !== 32'h8000_0000) $display("[TB] FAIL divovf_lo: got %h expected 80000000", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL divovf_hi: got %h expected 00000000", bus.hi); else passed++;
  endtask

  task automatic test_div_zero();
    int dc, bc, hv; logic dz, bd;
    // 629 / 18 = 34 r 17 leaves HI = 0x11, LO = 0x22
    run_op(1'b0, 1'b1, 32'd629, 32'd18, 32'h0, 32'h8000_0000, dc, bc, dz, bd, hv);
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22)
      $display("[TB] FAIL dz_setup: got hi=%h lo=%h expected hi=00000011 lo=00000022", bus.hi, bus.lo); else passed++;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 32'h11, 32'h22, dc, bc, dz, bd, hv);
`ifdef MULDIV_DIVZERO_EXC_EN
    total++; if (dc !== 1) $display("[TB] FAIL dz_done_cycle: got %0d expected 1", dc); else passed++;
    total++; if (dz !== 1'b1) $display("[TB] FAIL dz_flag: got %b expected 1", dz); else passed++;
    total++; if (bc !== 0) $display("[TB] FAIL dz_busy_cycles: got %0d expected 0", bc); else passed++;
    total++; if (bus.hi !== 32'h11) $display("[TB] FAIL dz_hi: got %h expected 00000011", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h22) $display("[TB] FAIL dz_lo: got %h expected 00000022", bus.lo); else passed++;
`else
    total++; if (dc !== 34) $display("[TB] FAIL dz_done_cycle: got %0d expected 34", dc); else passed++;
    total++; if (dz !== 1'b0) $display("[TB] FAIL dz_flag: got %b expected 0", dz); else passed++;
    total++; if (bus.hi !== 32'd5) $display("[TB] FAIL dz_hi: got %h expected 00000005", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFFF) $display("[TB] FAIL dz_lo: got %h expected ffffffff", bus.lo); else passed++;
`endif
  endtask

  task automatic test_simultaneous();
    int dc, bc, hv, dones, first_done; logic dz, bd, clear_next;
    run_op(1'b1, 1'b1, 32'd6, 32'd4, 32'h0, 32'h0, dc, bc, dz, bd, hv);
    total++; if (dc !== 33) $display("[TB] FAIL both_done_cycle: got %0d expected 33", dc); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL both_hi: got %h expected 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'd24) $display("[TB] FAIL both_lo: got %h expected 00000018", bus.lo); else passed++;
    // 2 x 3 with stray start_div pulses during MUL and in the FIN cycle
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd3);
    dones = 0; first_done = -1; clear_next = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_mult = 1'b0;
      if (n == 10) begin
        bus.start_div = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
      end else if (n == 11 || clear_next) begin
        bus.start_div = 1'b0; clear_next = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = n;
        bus.start_div = 1'b1; clear_next = 1'b1;
      end
    end
    total++; if (first_done !== 33) $display("[TB] FAIL ignore_done_cycle: got %0d expected 33", first_done); else passed++;
    total++; if (dones !== 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); else passed++;
    total++; if (bus.lo !== 32'd6) $display("[TB] FAIL ignore_lo: got %h expected 00000006", bus.lo); else passed++;
  endtask

  task automatic test_reset_mid();
    int dc, bc, hv, dones; logic dz, bd;
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd5);
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_mult = 1'b0;
      if (bus.done === 1'b1) dones++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      $display("[TB] FAIL rstmid_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo); else passed++;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("[TB] FAIL rstmid_no_done: got %0d done pulses expected 0", dones); else passed++;
    run_op(1'b1, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0, dc, bc, dz, bd, hv);
    total++; if (dc !== 33) $display("[TB] FAIL rstmid_fresh_done: got %0d expected 33", dc); else passed++;
    total++; if (bus.lo !== 32'd9) $display("[TB] FAIL rstmid_fresh_lo: got %h expected 00000009", bus.lo); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc, bc, hv; logic dz, bd;
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 32'h0, 32'd9, dc, bc, dz, bd, hv);
    total++; if (dc !== 33) $display("[TB] FAIL b2b_mult_done: got %0d expected 33", dc); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL b2b_mult_hi: got %h expected 00000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFF_FFFE) $display("[TB] FAIL b2b_mult_lo: got %h expected fffffffe", bus.lo); else passed++;
    // run_op presents the divide in the first IDLE cycle after FIN
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 32'h0, 32'hFFFF_FFFE, dc, bc, dz, bd, hv);
    total++; if (dc !== 34) $display("[TB] FAIL b2b_div_done: got %0d expected 34", dc); else passed++;
    total++; if (hv !== 0) $display("[TB] FAIL b2b_hilo_hold: got %0d changes expected 0", hv); else passed++;
    total++; if (bus.lo !== 32'd14) $display("[TB] FAIL b2b_div_lo: got %h expected 0000000e", bus.lo); else passed++;
    total++; if (bus.hi !== 32'd2) $display("[TB] FAIL b2b_div_hi: got %h expected 00000002", bus.hi); else passed++;
  endtask

  initial begin
    passed         = 0;
    total          = 0;
    reset          = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    $display("[TB] muldiv_sequencer directed tests");
    test_reset();
    test_mult_signed();
    test_div_signed();
    test_div_zero();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
